// File: rtl/syn_down_counter.sv
// Loadable synchronous down counter with one-shot / auto-reload modes,
// terminal-count flag, busy flag and a registered one-cycle done pulse.
module syn_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             reload,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      q_q      <= ZERO;
      period_q <= ZERO;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      period_q <= period_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    period_d = period_q;
    done_d   = 1'b0;

    if (load) begin
      // A load overrides any terminal step in the same cycle, so no done pulse.
      q_d      = load_val;
      period_d = load_val;
      state_d  = (load_val != ZERO) ? RUN : IDLE;
    end else begin
      unique case (state_q)
        RUN: begin
          if (en) begin
            if (q_q == ONE) begin
              done_d = 1'b1;
              if (reload) begin
                q_d = period_q;
              end else begin
                q_d     = ZERO;
                state_d = DONE;
              end
            end else if (q_q != ZERO) begin
              q_d = q_q - ONE;
            end else begin
              // Unreachable in normal use; park rather than wrap below zero.
              state_d = IDLE;
            end
          end
        end
        DONE: begin
          q_d = ZERO;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign q         = q_q;
  assign qb        = ~q_q;
  assign tc        = (q_q == ZERO);
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
